// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch and data load/store) sharing one memory port.
// Ties alternate using a last-grant register; each transaction ends with a one-cycle ready pulse.
module mem_port_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        I_strobe,
   input  logic [31:0] I_addr,
   output logic [31:0] I_rdata,
   output logic        I_ready,
   input  logic        D_strobe,
   input  logic        D_rw,
   input  logic [31:0] D_addr,
   input  logic [31:0] D_wdata,
   output logic [31:0] D_rdata,
   output logic        D_ready,
   output logic        M_strobe,
   output logic        M_rw,
   output logic [31:0] M_addr,
   output logic [31:0] M_wdata,
   input  logic [31:0] M_rdata,
   input  logic        M_ready
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
   typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_t;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   state_t      r_state;
   state_t      w_state_nxt;
   grant_t      r_grant;
   grant_t      r_last_grant;
   grant_t      w_winner;
   logic        w_grant_en;
   logic        w_complete;
   logic        r_rw;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_i_rdata;
   logic [31:0] r_d_rdata;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_en  = 1'b0;
      w_complete  = 1'b0;
      w_winner    = GNT_I;
      if (I_strobe && D_strobe) begin
         w_winner = (r_last_grant == GNT_D) ? GNT_I : GNT_D;
      end else if (D_strobe) begin
         w_winner = GNT_D;
      end

      case (r_state)
         ST_IDLE: begin
            if (I_strobe || D_strobe) begin
               w_state_nxt = ST_BUSY;
               w_grant_en  = 1'b1;
            end
         end
         ST_BUSY: begin
            if (M_ready) begin
               w_state_nxt = ST_RESP;
               w_complete  = 1'b1;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= GNT_D;
         r_grant      <= GNT_I;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_en) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
         end
      end
   end

   // Request is captured at grant so a requester dropping strobe mid-flight cannot disturb the memory side.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rw    <= 1'b1;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_grant_en) begin
         if (w_winner == GNT_I) begin
            r_rw    <= 1'b1;
            r_addr  <= I_addr;
            r_wdata <= '0;
         end else begin
            r_rw    <= D_rw;
            r_addr  <= D_addr;
            r_wdata <= D_wdata;
         end
      end
   end

   // Read data registers only move on a read completion for their own side.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_i_rdata <= NOP_INSN;
         r_d_rdata <= '0;
      end else if (w_complete && r_rw) begin
         if (r_grant == GNT_I) begin
            r_i_rdata <= M_rdata;
         end else begin
            r_d_rdata <= M_rdata;
         end
      end
   end

   assign M_strobe = (r_state == ST_BUSY);
   assign M_rw     = r_rw;
   assign M_addr   = r_addr;
   assign M_wdata  = r_wdata;
   assign I_ready  = (r_state == ST_RESP) && (r_grant == GNT_I);
   assign D_ready  = (r_state == ST_RESP) && (r_grant == GNT_D);
   assign I_rdata  = r_i_rdata;
   assign D_rdata  = r_d_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports named as below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous reset, active-low.
REQ-004 I_strobe  input  1  instruction-side request; I side always reads.
REQ-005 I_addr  input  32  instruction-side address.
REQ-006 I_rdata  output  32  instruction-side read data.
REQ-007 I_ready  output  1  instruction-side completion pulse.
REQ-008 D_strobe  input  1  data-side request.
REQ-009 D_rw  input  1  data-side direction: 1 = read, 0 = write.
REQ-010 D_addr  input  32  data-side address.
REQ-011 D_wdata  input  32  data-side write data.
REQ-012 D_rdata  output  32  data-side read data.
REQ-013 D_ready  output  1  data-side completion pulse.
REQ-014 M_strobe  output  1  memory request.
REQ-015 M_rw  output  1  memory direction: 1 = read, 0 = write.
REQ-016 M_addr  output  32  memory address.
REQ-017 M_wdata  output  32  memory write data.
REQ-018 M_rdata  input  32  memory read data; valid when M_ready = 1.
REQ-019 M_ready  input  1  memory one-cycle completion pulse.

Function
REQ-020 FSM SHALL have three states:
- IDLE: no grant.
- BUSY: memory transaction in flight.
- RESP: one-cycle completion to the granted requester.
REQ-021 Requester handshake:
- A requester holds strobe, addr, rw and wdata stable from assertion until its ready pulse.
- It deasserts strobe no later than the cycle after ready.
REQ-022 Grant: in IDLE with any strobe high, the FSM SHALL move to BUSY at the next edge and latch the winner, addr, rw and wdata into registers.
REQ-023 Single request: if only one strobe is high, that requester SHALL win.
REQ-024 Simultaneous requests: if both strobes are high, the requester not granted last (last_grant register) SHALL win. last_grant resets to D, so I wins the first tie.
REQ-025 In BUSY:
- M_strobe SHALL be 1.
- M_addr, M_rw and M_wdata SHALL be driven from the latched registers and stay constant until M_ready.
- M_rw SHALL be 1 whenever I is granted.
REQ-026 On M_ready = 1 in BUSY, at the next edge:
- The FSM SHALL enter RESP.
- M_strobe SHALL drop to 0.
- For a read, M_rdata SHALL be captured into the granted side's rdata register.
- For a D write, D_rdata SHALL be left unchanged.
REQ-027 In RESP:
- Only the granted side's ready SHALL be 1, for exactly one cycle.
- Both strobes SHALL be ignored.
- The FSM SHALL return to IDLE at the next edge.
REQ-028 I_rdata and D_rdata SHALL hold their values until the next read completion for that side.
REQ-029 Latency: with strobe sampled at edge 0 and M_ready high in cycle k (k ≥ 1), the ready pulse SHALL be in cycle k+1. The earliest next M_strobe SHALL be in cycle k+3.
REQ-030 A strobe that drops while the FSM is in BUSY SHALL NOT abort the transaction; it completes and ready still pulses.
REQ-031 M_ready asserted outside BUSY SHALL be ignored.
REQ-032 The losing requester SHALL remain pending, with no ready, until granted in a later IDLE.
REQ-033 I_ready and D_ready SHALL never be 1 in the same cycle. M_strobe SHALL never be 1 outside BUSY.

Reset
REQ-034 While rst = 0, asynchronously:
- FSM = IDLE; last_grant = D.
- M_strobe = 0; M_rw = 1; M_addr = 0; M_wdata = 0.
- I_ready = 0; D_ready = 0.
- I_rdata = 32'h00000013 (NOP); D_rdata = 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction without any ready pulse. After release, the arbiter SHALL start in IDLE and accept new requests.

Verification
REQ-036 Bench SHALL cover:
- I read alone: I_strobe = 1, I_addr = 0x100; memory answers M_rdata = 0xDEADBEEF at k = 3. Required: M_rw = 1, M_addr = 0x100, I_ready pulse in cycle 4, I_rdata = 0xDEADBEEF.
- Simultaneous requests after reset: I_addr = 0x0, D read D_addr = 0x200. Required: I served first, then D served next; D_ready arrives after I_ready.
- D write: D_rw = 0, D_addr = 0x40, D_wdata = 0x12345678. Required: M_rw = 0, M_wdata = 0x12345678, D_ready pulse, D_rdata unchanged.
- Two back-to-back ties: grants alternate I, D, I, D; ready never pulses on both sides in the same cycle.
- Reset during BUSY: reset asserted after M_strobe rises and before M_ready. Required: all outputs at reset values, no ready pulse; next I read completes normally.
- Stray M_ready while in IDLE: no state change, no ready pulse.
